// File: rtl/mul_hilo_unit_if.sv
// Request/result bundle between a HI/LO owner (slave) and its requester (master).
// mul_unsigned exists only when MUL_UNSIGNED_EN is defined.
// Back-pressure: the requester holds mul_start until it sees mul_ready at a clock edge.
interface mul_hilo_unit_if;
  logic        mul_start;
  logic        mul_ready;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] bus_data;
  logic        hi_in;
  logic        lo_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mul_busy;
  logic        mul_done;
`ifdef MUL_UNSIGNED_EN
  logic        mul_unsigned;
`endif

  modport master (
    output mul_start, mul_a, mul_b, bus_data, hi_in, lo_in,
`ifdef MUL_UNSIGNED_EN
    output mul_unsigned,
`endif
    input  mul_ready, hi_out, lo_out, mul_busy, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, bus_data, hi_in, lo_in,
`ifdef MUL_UNSIGNED_EN
    input  mul_unsigned,
`endif
    output mul_ready, hi_out, lo_out, mul_busy, mul_done
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// Multi-cycle 32x32 signed multiply controller owning the HI/LO registers; MUL_UNSIGNED_EN adds unsigned mode.
// Latency: HI/LO written LATENCY edges after the accepting edge, mul_done high the cycle after.
// Back-pressure: mul_ready low while BUSY; a mul_start then is ignored, not queued.
module mul_hilo_unit #(
  parameter int unsigned LATENCY = 2
) (
  input  logic           clk,
  input  logic           clr_n,
  mul_hilo_unit_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic [63:0] product;
`ifdef MUL_UNSIGNED_EN
  logic        uns_q, uns_d;
`endif

  // Full-width signed product of two 32-bit two's-complement operands.
  function automatic logic [63:0] multiplier_32b(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    return a_ext * b_ext;
  endfunction

  // Only the op registers feed the multiplier, so the product is a stable multi-cycle path.
  always_comb begin
    logic [63:0] prod_s;
    logic [63:0] corr;
    prod_s  = multiplier_32b(op_a_q, op_b_q);
    corr    = '0;
`ifdef MUL_UNSIGNED_EN
    if (uns_q) begin
      corr = (op_a_q[31] ? {op_b_q, 32'h0} : 64'h0)
           + (op_b_q[31] ? {op_a_q, 32'h0} : 64'h0);
    end
`endif
    product = prod_s + corr;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MUL_UNSIGNED_EN
    uns_d   = uns_q;
`endif

    if (bus.hi_in) hi_d = bus.bus_data;
    if (bus.lo_in) lo_d = bus.bus_data;

    unique case (state_q)
      IDLE: begin
        if (bus.mul_start) begin
          state_d = BUSY;
          op_a_d  = bus.mul_a;
          op_b_d  = bus.mul_b;
          cnt_d   = CNT_INIT;
`ifdef MUL_UNSIGNED_EN
          uns_d   = bus.mul_unsigned;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          // Writeback overrides any bus load on the same edge.
          state_d = IDLE;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MUL_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MUL_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign bus.mul_ready = (state_q == IDLE);
  assign bus.mul_busy  = (state_q == BUSY);
  assign bus.mul_done  = done_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Scoreboard bench for mul_hilo_unit (LATENCY=2); unsigned cases run only with MUL_UNSIGNED_EN.
module tb_mul_hilo_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic clr_n;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  mul_hilo_unit_if bus_if ();

  mul_hilo_unit #(.LATENCY(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && bus_if.mul_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", 64'(bus_if.hi_out), 64'(e.hi));
        chk("sb_lo", 64'(bus_if.lo_out), 64'(e.lo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds mul_start until accepted; returns 1 ns after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic uns,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit push);
    logic acc;
    int   n;
    exp_t e;
    bus_if.mul_start = 1'b1;
    bus_if.mul_a     = a;
    bus_if.mul_b     = b;
`ifdef MUL_UNSIGNED_EN
    bus_if.mul_unsigned = uns;
`else
    if (uns) chk("uns_not_built", 64'd1, 64'd0);
`endif
    n = 0;
    forever begin
      acc = bus_if.mul_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 40) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      sb.push_back(e);
    end
    bus_if.mul_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      tick();
      if (bus_if.mul_done === 1'b1) break;
      n++;
      if (n > 40) begin
        chk("done_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus_if.mul_start = 1'b0;
    bus_if.mul_a     = '0;
    bus_if.mul_b     = '0;
    bus_if.bus_data  = '0;
    bus_if.hi_in     = 1'b0;
    bus_if.lo_in     = 1'b0;
`ifdef MUL_UNSIGNED_EN
    bus_if.mul_unsigned = 1'b0;
`endif
    clr_n = 1'b1;
    #2 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(bus_if.hi_out), 64'd0);
    chk("rst_lo", 64'(bus_if.lo_out), 64'd0);
    chk("rst_ready", 64'(bus_if.mul_ready), 64'd1);
    chk("rst_busy", 64'(bus_if.mul_busy), 64'd0);
    chk("rst_done", 64'(bus_if.mul_done), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    tick();

    // 15*10 with cycle-exact timing
    issue(32'd15, 32'd10, 1'b0, 32'h0, 32'h96, 1'b1);
    chk("t1_busy_e0", 64'(bus_if.mul_busy), 64'd1);
    chk("t1_ready_e0", 64'(bus_if.mul_ready), 64'd0);
    tick();
    chk("t1_busy_e1", 64'(bus_if.mul_busy), 64'd1);
    chk("t1_lo_e1", 64'(bus_if.lo_out), 64'd0);
    chk("t1_done_e1", 64'(bus_if.mul_done), 64'd0);
    tick();
    chk("t1_busy_e2", 64'(bus_if.mul_busy), 64'd0);
    chk("t1_done_e2", 64'(bus_if.mul_done), 64'd1);
    chk("t1_lo_e2", 64'(bus_if.lo_out), 64'h96);
    tick();
    chk("t1_done_e3", 64'(bus_if.mul_done), 64'd0);

    // back-to-back: second start issued in the done cycle
    issue(-32'sd15, -32'sd10, 1'b0, 32'h0, 32'h96, 1'b1);
    wait_done();
    issue(32'd15, -32'sd10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FF6A, 1'b1);
    chk("t2_no_gap_busy", 64'(bus_if.mul_busy), 64'd1);
    chk("t2_no_gap_done", 64'(bus_if.mul_done), 64'd0);
    wait_done();
    chk("t2_hi", 64'(bus_if.hi_out), 64'hFFFF_FFFF);

    // extreme operands
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, 1'b1);
    wait_done();
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h0, 32'h7FFF_FFFF, 1'b1);
    wait_done();

    // start while busy is ignored; bus load on writeback edge loses
    issue(32'd3, 32'd4, 1'b0, 32'h0, 32'd12, 1'b1);
    bus_if.mul_start = 1'b1;
    bus_if.mul_a     = 32'd5;
    bus_if.mul_b     = 32'd6;
    tick();
    bus_if.mul_start = 1'b0;
    bus_if.hi_in     = 1'b1;
    bus_if.bus_data  = 32'hDEAD;
    tick();
    bus_if.hi_in = 1'b0;
    chk("t4_wb_done", 64'(bus_if.mul_done), 64'd1);
    chk("t4_wb_hi", 64'(bus_if.hi_out), 64'd0);
    tick();
    chk("t4_ignored_busy", 64'(bus_if.mul_busy), 64'd0);
    bus_if.hi_in = 1'b1;
    tick();
    bus_if.hi_in = 1'b0;
    chk("t4_idle_hi", 64'(bus_if.hi_out), 64'hDEAD);
    chk("t4_idle_lo", 64'(bus_if.lo_out), 64'd12);
    bus_if.hi_in    = 1'b1;
    bus_if.lo_in    = 1'b1;
    bus_if.bus_data = 32'h1234_5678;
    tick();
    bus_if.hi_in = 1'b0;
    bus_if.lo_in = 1'b0;
    chk("t4_both_hi", 64'(bus_if.hi_out), 64'h1234_5678);
    chk("t4_both_lo", 64'(bus_if.lo_out), 64'h1234_5678);

    // reset mid-busy discards the multiply
    issue(32'd7, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
    #3 clr_n = 1'b0;
    #1;
    chk("t5_hi", 64'(bus_if.hi_out), 64'd0);
    chk("t5_lo", 64'(bus_if.lo_out), 64'd0);
    chk("t5_ready", 64'(bus_if.mul_ready), 64'd1);
    chk("t5_busy", 64'(bus_if.mul_busy), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_done", 64'(bus_if.mul_done), 64'd0);
    end

`ifdef MUL_UNSIGNED_EN
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h1, 1'b1);
    wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'd2, 1'b1, 32'h1, 32'h0, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_done();
`endif

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
